// File: rtl/dbg_controller.sv
// Debug-port sequencer driving the processor DBG_* inputs from a host command link.
// Optional DBG_CMDCNT_EN adds a 16-bit accepted-command counter reported in STATUS[31:16].
module dbg_controller #(
  parameter int HALT_DRAIN = 5,
  parameter int RST_CYCLES = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic [2:0]  iCmd,
  input  logic [4:0]  iCmdAddr,
  input  logic [31:0] iCmdData,
  output logic        oRspValid,
  input  logic        iRspReady,
  output logic [31:0] oRspData,
  output logic        oRspErr,
  output logic        oDBG_halt,
  output logic        oDBG_exec,
  output logic [31:0] oDBG_ins,
  output logic        oDBG_regWrite,
  output logic [4:0]  oDBG_rsAddr,
  output logic [31:0] oDBG_rdValue,
  input  logic [31:0] iDBG_rsValue,
  output logic        oDBG_nRst
);

  localparam int CNT_MAX = (HALT_DRAIN > RST_CYCLES) ? HALT_DRAIN : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_RUN      = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_HALTED   = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_RDWAIT   = 3'd4;
  localparam logic [2:0] S_WRPULSE  = 3'd5;
  localparam logic [2:0] S_CORE_RST = 3'd6;
  localparam logic [2:0] S_RESP     = 3'd7;

  localparam logic [2:0] OP_STATUS   = 3'd0;
  localparam logic [2:0] OP_HALT     = 3'd1;
  localparam logic [2:0] OP_RESUME   = 3'd2;
  localparam logic [2:0] OP_STEP     = 3'd3;
  localparam logic [2:0] OP_EXEC     = 3'd4;
  localparam logic [2:0] OP_REG_RD   = 3'd5;
  localparam logic [2:0] OP_REG_WR   = 3'd6;
  localparam logic [2:0] OP_CORE_RST = 3'd7;

  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             dbg_halt;
  logic             dbg_exec;
  logic [31:0]      dbg_ins;
  logic             dbg_reg_write;
  logic [4:0]       rs_addr;
  logic [31:0]      rd_value;
  logic             dbg_nrst;
  logic [31:0]      status_word;
  logic             accept;

  assign oCmdReady = (state == S_RUN) || (state == S_HALTED);
  assign accept    = iCmdValid && oCmdReady;

`ifdef DBG_CMDCNT_EN
  logic [15:0] cmd_cnt;

  // The STATUS command reporting the count is itself counted.
  assign status_word = {cmd_cnt + 16'd1, 15'd0, halted};

  always_ff @(posedge iClk) begin
    if (iRst)        cmd_cnt <= '0;
    else if (accept) cmd_cnt <= cmd_cnt + 16'd1;
  end
`else
  assign status_word = {16'd0, 15'd0, halted};
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state         <= S_RUN;
      halted        <= 1'b0;
      cnt           <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      dbg_halt      <= 1'b0;
      dbg_exec      <= 1'b0;
      dbg_ins       <= '0;
      dbg_reg_write <= 1'b0;
      rs_addr       <= '0;
      rd_value      <= '0;
      dbg_nrst      <= 1'b1;
    end else begin
      dbg_exec      <= 1'b0;
      dbg_reg_write <= 1'b0;
      case (state)
        S_RUN, S_HALTED: begin
          if (accept) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
            case (iCmd)
              OP_STATUS: rsp_data <= status_word;
              OP_HALT: begin
                if (!halted) begin
                  dbg_halt <= 1'b1;
                  cnt      <= CNT_W'(HALT_DRAIN);
                  state    <= S_DRAIN;
                end
              end
              OP_RESUME: begin
                dbg_halt <= 1'b0;
                halted   <= 1'b0;
              end
              OP_CORE_RST: begin
                dbg_nrst <= 1'b0;
                cnt      <= CNT_W'(RST_CYCLES);
                state    <= S_CORE_RST;
              end
              default: begin
                // Remaining opcodes need a halted core; in RUN they only report an error.
                if (!halted) begin
                  rsp_err <= 1'b1;
                end else if (iCmd == OP_STEP) begin
                  dbg_halt <= 1'b0;
                  state    <= S_EXEC;
                end else if (iCmd == OP_EXEC) begin
                  dbg_ins  <= iCmdData;
                  dbg_exec <= 1'b1;
                  state    <= S_EXEC;
                end else if (iCmd == OP_REG_RD) begin
                  rs_addr <= iCmdAddr;
                  cnt     <= CNT_W'(1);
                  state   <= S_RDWAIT;
                end else begin
                  rs_addr       <= iCmdAddr;
                  rd_value      <= iCmdData;
                  dbg_reg_write <= 1'b1;
                  state         <= S_WRPULSE;
                end
              end
            endcase
          end
        end
        S_EXEC: begin
          dbg_halt <= 1'b1;
          cnt      <= CNT_W'(HALT_DRAIN);
          state    <= S_DRAIN;
        end
        S_DRAIN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            halted <= 1'b1;
            state  <= S_RESP;
          end
        end
        S_RDWAIT: begin
          // Register file data lags the address by one cycle.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_data <= iDBG_rsValue;
            state    <= S_RESP;
          end
        end
        S_WRPULSE: state <= S_RESP;
        S_CORE_RST: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            dbg_nrst <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (iRspReady) state <= halted ? S_HALTED : S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign oRspValid     = (state == S_RESP);
  assign oRspData      = rsp_data;
  assign oRspErr       = rsp_err;
  assign oDBG_halt     = dbg_halt;
  assign oDBG_exec     = dbg_exec;
  assign oDBG_ins      = dbg_ins;
  assign oDBG_regWrite = dbg_reg_write;
  assign oDBG_rsAddr   = rs_addr;
  assign oDBG_rdValue  = rd_value;
  assign oDBG_nRst     = dbg_nrst;

endmodule

// File: tb/tb_dbg_controller.sv
// Randomized bench for dbg_controller against a command-level reference model
// with an attached register-file model.
module tb_dbg_controller;

  localparam int HALT_DRAIN = 5;
  localparam int RST_CYCLES = 4;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iCmdValid = 1'b0;
  logic        oCmdReady;
  logic [2:0]  iCmd = '0;
  logic [4:0]  iCmdAddr = '0;
  logic [31:0] iCmdData = '0;
  logic        oRspValid;
  logic        iRspReady = 1'b0;
  logic [31:0] oRspData;
  logic        oRspErr;
  logic        oDBG_halt;
  logic        oDBG_exec;
  logic [31:0] oDBG_ins;
  logic        oDBG_regWrite;
  logic [4:0]  oDBG_rsAddr;
  logic [31:0] oDBG_rdValue;
  logic [31:0] iDBG_rsValue;
  logic        oDBG_nRst;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic        m_halted;
  logic [15:0] m_cnt;
  logic [31:0] m_ins;
  logic [31:0] m_rf [32];

  // Processor register file seen through the debug port
  logic [31:0] rf [32];

  always #5 iClk = ~iClk;

  dbg_controller #(.HALT_DRAIN(HALT_DRAIN), .RST_CYCLES(RST_CYCLES)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmd(iCmd), .iCmdAddr(iCmdAddr), .iCmdData(iCmdData),
    .oRspValid(oRspValid), .iRspReady(iRspReady),
    .oRspData(oRspData), .oRspErr(oRspErr),
    .oDBG_halt(oDBG_halt), .oDBG_exec(oDBG_exec), .oDBG_ins(oDBG_ins),
    .oDBG_regWrite(oDBG_regWrite), .oDBG_rsAddr(oDBG_rsAddr),
    .oDBG_rdValue(oDBG_rdValue), .iDBG_rsValue(iDBG_rsValue),
    .oDBG_nRst(oDBG_nRst)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_word(i);
    end else if (oDBG_regWrite) begin
      rf[oDBG_rsAddr] <= oDBG_rdValue;
    end
    iDBG_rsValue <= rf[oDBG_rsAddr];
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 1'b0;
    m_cnt    = '0;
    m_ins    = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = init_word(i);
  endtask

  function automatic logic [15:0] cnt_field(logic [15:0] c);
`ifdef DBG_CMDCNT_EN
    return c;
`else
    return 16'd0 & c;
`endif
  endfunction

  task automatic do_cmd(input logic [2:0] cmd, input logic [4:0] addr,
                        input logic [31:0] data, input int hold_in);
    logic [31:0] e_data = '0;
    logic        e_err = 1'b0;
    int          e_lat = 1;
    bit          lat_exact = 1'b1;
    int          e_exec = 0, e_wr = 0, e_nrst = 0, e_halt_low = 0;
    bit          chk_halt_low = 1'b0, chk_halt_rise = 1'b0;
    int          lat = 0, n_exec = 0, n_wr = 0, n_nrst = 0, n_halt_low = 0;
    logic [4:0]  wr_addr = '0, prev_rs;
    logic [31:0] wr_data = '0, d0;
    logic        halt_at1 = 1'b0, e0;
    bit          stable = 1'b1;
    int          w = 0;
    int          hold = (hold_in < 0) ? int'($urandom_range(0, 3)) : hold_in;

    while (!oCmdReady && w < 50) begin @(negedge iClk); w++; end
    check("cmd_ready_wait", {31'd0, oCmdReady}, 32'd1);
    prev_rs = oDBG_rsAddr;

    m_cnt = m_cnt + 16'd1;
    case (cmd)
      3'd0: e_data = {cnt_field(m_cnt), 15'd0, m_halted};
      3'd1: begin
        if (!m_halted) begin e_lat = HALT_DRAIN + 1; chk_halt_rise = 1'b1; end
        m_halted = 1'b1;
      end
      3'd2: m_halted = 1'b0;
      3'd7: begin e_nrst = RST_CYCLES; e_lat = RST_CYCLES + 1; lat_exact = 1'b0; end
      default: begin
        if (!m_halted) begin
          e_err = 1'b1;
        end else if (cmd == 3'd3) begin
          e_lat = HALT_DRAIN + 1; lat_exact = 1'b0; chk_halt_low = 1'b1; e_halt_low = 1;
        end else if (cmd == 3'd4) begin
          m_ins = data; e_exec = 1; e_lat = HALT_DRAIN + 1; lat_exact = 1'b0;
          chk_halt_low = 1'b1;
        end else if (cmd == 3'd5) begin
          e_data = m_rf[addr]; e_lat = 2; lat_exact = 1'b0;
        end else begin
          m_rf[addr] = data; e_wr = 1; e_lat = 2; lat_exact = 1'b0;
        end
      end
    endcase

    iCmd = cmd; iCmdAddr = addr; iCmdData = data; iCmdValid = 1'b1;
    @(posedge iClk);
    #1 iCmdValid = 1'b0;
    iCmd = 3'($urandom); iCmdAddr = 5'($urandom); iCmdData = $urandom;

    do begin
      @(negedge iClk);
      lat++;
      if (oDBG_exec) n_exec++;
      if (oDBG_regWrite) begin n_wr++; wr_addr = oDBG_rsAddr; wr_data = oDBG_rdValue; end
      if (!oDBG_nRst) n_nrst++;
      if (!oDBG_halt) n_halt_low++;
      if (lat == 1) halt_at1 = oDBG_halt;
    end while (!oRspValid && lat < 200);
    check("rsp_timeout", {31'd0, oRspValid}, 32'd1);

    d0 = oRspData; e0 = oRspErr;
    for (int h = 0; h < hold; h++) begin
      @(negedge iClk);
      if (oRspData !== d0 || oRspErr !== e0 || !oRspValid || oCmdReady) stable = 1'b0;
    end
    check("rsp_stable", {31'd0, stable}, 32'd1);
    check("rsp_err", {31'd0, oRspErr}, {31'd0, e_err});
    check("rsp_data", oRspData, e_data);
    if (lat_exact) check("latency", lat, e_lat);
    else           check("latency_min", {31'd0, lat >= e_lat}, 32'd1);
    check("exec_pulses", n_exec, e_exec);
    check("wr_pulses", n_wr, e_wr);
    if (e_wr == 1) begin
      check("wr_addr", {27'd0, wr_addr}, {27'd0, addr});
      check("wr_data", wr_data, data);
    end
    check("nrst_low_cycles", n_nrst, e_nrst);
    if (chk_halt_low) check("halt_low_cycles", n_halt_low, e_halt_low);
    if (chk_halt_rise) check("halt_rise", {31'd0, halt_at1}, 32'd1);
    if (e_err) check("err_rs_addr", {27'd0, oDBG_rsAddr}, {27'd0, prev_rs});
    check("dbg_ins", oDBG_ins, m_ins);

    iRspReady = 1'b1;
    @(posedge iClk);
    #1 iRspReady = 1'b0;
    @(negedge iClk);
    check("post_ready", {30'd0, oCmdReady, oRspValid}, 32'b10);
    check("post_halt", {31'd0, oDBG_halt}, {31'd0, m_halted});
    repeat ($urandom_range(0, 2)) @(negedge iClk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge iClk);
    check("reset_ready", {31'd0, oCmdReady}, 32'd1);
    check("reset_rsp", {oRspErr, oRspValid, oRspData[29:0]}, 32'd0);
    check("reset_dbg", {oDBG_nRst, oDBG_halt, oDBG_exec, oDBG_regWrite, oDBG_rsAddr},
          32'h0000_0100);
    check("reset_ins_rd", oDBG_ins | oDBG_rdValue, 32'd0);
    iRst = 1'b0;
    @(negedge iClk);

    do_cmd(3'd0, 5'd0, 32'd0, 0);            // STATUS after reset
    do_cmd(3'd5, 5'd7, 32'd0, 0);            // REG_RD in RUN -> error
    do_cmd(3'd1, 5'd0, 32'd0, 0);            // HALT with drain
    do_cmd(3'd0, 5'd0, 32'd0, 1);            // STATUS halted
    do_cmd(3'd1, 5'd0, 32'd0, 0);            // HALT when halted
    do_cmd(3'd6, 5'd3, 32'hDEAD_BEEF, 0);    // REG_WR
    do_cmd(3'd5, 5'd3, 32'd0, 0);            // REG_RD back
    do_cmd(3'd5, 5'd0, 32'd0, 0);            // REG_RD x0
    do_cmd(3'd4, 5'd0, 32'h0050_0093, 0);    // EXEC
    do_cmd(3'd3, 5'd0, 32'd0, 10);           // STEP with long response stall
    do_cmd(3'd7, 5'd0, 32'd0, 0);            // CORE_RST while halted
    do_cmd(3'd0, 5'd0, 32'd0, 0);
    do_cmd(3'd2, 5'd0, 32'd0, 0);            // RESUME
    do_cmd(3'd2, 5'd0, 32'd0, 0);            // RESUME in RUN
    do_cmd(3'd7, 5'd0, 32'd0, 0);            // CORE_RST while running

    for (int n = 0; n < 250; n++)
      do_cmd(3'($urandom_range(0, 7)), 5'($urandom), $urandom, -1);

    if (m_halted) do_cmd(3'd2, 5'd0, 32'd0, 0);
    iCmd = 3'd1; iCmdValid = 1'b1;
    @(posedge iClk);
    #1 iCmdValid = 1'b0;
    repeat (2) @(negedge iClk);
    check("drain_halt", {30'd0, oDBG_halt, oRspValid}, 32'b10);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    check("abort_state", {28'd0, oDBG_halt, oRspValid, oCmdReady, oDBG_nRst}, 32'b0011);
    check("abort_ins", oDBG_ins, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    model_reset();
    @(negedge iClk);
    do_cmd(3'd0, 5'd0, 32'd0, 0);
    do_cmd(3'd5, 5'd1, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
